onehot_rr_arbiter: RTL and testbench

ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

---
 rtl/onehot_rr_arbiter_if.sv | 27 ++
 rtl/onehot_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_onehot_rr_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/onehot_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// onehot_rr_arbiter_if
// Request/grant bundle between four requesters and the one-hot arbiter.
//   req     [3:0] request vector, requester i drives bit [3-i]
//   done          current owner releases its grant this cycle
//   grant   [3:0] registered one-hot grant (or 0), drives a one-hot mux select
//   valid         high exactly when grant is non-zero
//   owner   [1:0] index of the granted requester, sticky while valid is low
//   timeout       one-cycle pulse when a grant was released by force
// Modports: master = requester side, slave = arbiter side.
//
// Handshake: a requester holds its req bit high until it sees itself in
// grant; the owner keeps the grant for as long as it likes and raises done
// for one cycle to release it. The next owner (if any) is visible on the
// very next cycle, so grant never goes through 0 between two owners.
// ---------------------------------------------------------------------------
interface onehot_rr_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       valid;
  logic [1:0] owner;
  logic       timeout;

  modport master (output req, done, input grant, valid, owner, timeout);
  modport slave  (input req, done, output grant, valid, owner, timeout);
endinterface

// File: rtl/onehot_rr_arbiter.sv
// ---------------------------------------------------------------------------
// onehot_rr_arbiter
// Four-way round-robin arbiter with a registered one-hot grant that is held
// until the owner signals done.
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   bus          onehot_rr_arbiter_if.slave (req, done in; grant, valid,
//                owner, timeout out)
//   o_dbg_state  FSM state (0 = IDLE, 1 = BUSY)
// Parameter TIMEOUT (2..255): grant-hold limit in cycles, used only when the
// macro ARB_TIMEOUT_EN is defined. Without the macro grants are held until
// done and timeout is tied low.
// ---------------------------------------------------------------------------
module onehot_rr_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onehot_rr_arbiter_if.slave    bus,
  output logic                  o_dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_grant, w_grant_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [1:0] r_ptr,   w_ptr_nxt;
  logic       r_valid, w_valid_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic       w_force;
  logic       w_new_grant;
  logic [2:0] w_pick_idle;
  logic [2:0] w_pick_busy;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("onehot_rr_arbiter: TIMEOUT must be in 2..255");
  end

  // Returns {found, index}. Search order is p+1, p+2, p+3, p, so the
  // pointer's own index only wins when nobody else is requesting.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = p + k[1:0];
      if (r[2'd3 - idx]) pick = {1'b1, idx};
    end
  endfunction

  // Requester i maps to bit [3-i].
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b1000 >> idx;
  endfunction

  assign w_pick_idle = pick(bus.req, r_ptr);
  assign w_pick_busy = pick(bus.req, r_owner);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] r_hold_cnt;

  assign w_force = (r_state == S_BUSY) && !bus.done
                   && (r_hold_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)                             r_hold_cnt <= 8'd0;
    else if (w_new_grant)                   r_hold_cnt <= 8'd0;
    else if (r_state == S_BUSY && !bus.done) r_hold_cnt <= r_hold_cnt + 8'd1;
  end
`else
  assign w_force = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    w_new_grant   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_idle[2]) begin
          w_state_nxt = S_BUSY;
          w_grant_nxt = onehot(w_pick_idle[1:0]);
          w_owner_nxt = w_pick_idle[1:0];
          w_ptr_nxt   = w_pick_idle[1:0];
          w_valid_nxt = 1'b1;
          w_new_grant = 1'b1;
        end
      end
      S_BUSY: begin
        // A forced release behaves exactly like done, plus the pulse.
        if (bus.done || w_force) begin
          w_timeout_nxt = w_force;
          if (w_pick_busy[2]) begin
            w_grant_nxt = onehot(w_pick_busy[1:0]);
            w_owner_nxt = w_pick_busy[1:0];
            w_ptr_nxt   = w_pick_busy[1:0];
            w_new_grant = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = 4'b0000;
            w_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= 4'b0000;
      r_owner   <= 2'd0;
      r_ptr     <= 2'd3;   // first search after reset starts at requester 0
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.grant   = r_grant;
  assign bus.valid   = r_valid;
  assign bus.owner   = r_owner;
  assign bus.timeout = r_timeout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_onehot_rr_arbiter
// Directed scenarios plus random traffic against a behavioural model of the
// round-robin arbiter. Build with ARB_TIMEOUT_EN to exercise the forced
// release path with TIMEOUT=4.
// ---------------------------------------------------------------------------
module tb_onehot_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO    = 4;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 16;
  localparam bit TMO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic dbg_state;
  always #5 clk = ~clk;

  onehot_rr_arbiter_if bus ();

  onehot_rr_arbiter #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_grant;
  logic       m_valid;
  logic [1:0] m_owner;
  logic       m_to;
  int         m_ptr;
  int         m_cnt;

  function automatic int rr_next(input logic [3:0] rq, input int p);
    int c;
    for (int s = 1; s <= 4; s++) begin
      c = (p + s) % 4;
      if (rq[3 - c]) return c;
    end
    return 0;
  endfunction

  task automatic grant_to(input int n);
    m_owner = n[1:0];
    m_ptr   = n;
    m_grant = 4'b0001 << (3 - n);
    m_valid = 1'b1;
    m_cnt   = 0;
  endtask

  task automatic model_update(input logic r, input logic [3:0] rq, input logic d);
    logic frc;
    m_to = 1'b0;
    if (!r) begin
      m_grant = 4'b0000; m_valid = 1'b0; m_owner = 2'd0; m_ptr = 3; m_cnt = 0;
    end else if (!m_valid) begin
      if (rq != 4'b0000) grant_to(rr_next(rq, m_ptr));
    end else begin
      frc = TMO_EN && !d && (m_cnt == TMO - 1);
      if (d || frc) begin
        m_to = frc;
        if (rq != 4'b0000) grant_to(rr_next(rq, int'(m_owner)));
        else begin
          m_grant = 4'b0000;
          m_valid = 1'b0;
        end
      end else begin
        m_cnt++;
      end
    end
  endtask

  // ---------------- driver ----------------
  int cyc = 0;

  task automatic step(input logic r, input logic [3:0] rq, input logic d);
    logic [8:0] e, o;
    rst_n    = r;
    bus.req  = rq;
    bus.done = d;
    model_update(r, rq, d);
    exp_q.push_back({m_valid, m_grant, m_valid, m_owner, m_to});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {dbg_state, bus.grant, bus.valid, bus.owner, bus.timeout};
    check_eq($sformatf("cyc%0d_state_grant_valid_owner_to", cyc), 32'(o), 32'(e));
    cyc++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] seq [4];
    int h, rel;
    logic d;
    logic [3:0] eg;
    seq[0] = 4'b0100; seq[1] = 4'b0010; seq[2] = 4'b0001; seq[3] = 4'b1000;

    // reset values
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    check_eq("reset_grant", 32'(bus.grant), 32'h0);
    check_eq("reset_owner", 32'(bus.owner), 32'h0);
    check_eq("reset_valid", 32'(bus.valid), 32'h0);

    // single requester 2, one-cycle latency
    step(1'b1, 4'b0010, 1'b0);
    check_eq("single_grant", 32'(bus.grant), 32'h2);
    check_eq("single_owner", 32'(bus.owner), 32'd2);
    check_eq("single_valid", 32'(bus.valid), 32'h1);
    step(1'b1, 4'b0000, 1'b1);

    // saturated load, done every 3rd granted cycle
    step(1'b0, 4'b0000, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    check_eq("sat_first", 32'(bus.grant), 32'h8);
    h = 1; rel = 0;
    while (rel < 4) begin
      d = (h == 3);
      step(1'b1, 4'b1111, d);
      check_eq("sat_no_bubble", 32'(bus.valid), 32'h1);
      if (d) begin
        check_eq($sformatf("sat_seq%0d", rel), 32'(bus.grant), 32'(seq[rel]));
        rel++;
        h = 1;
      end else begin
        h++;
      end
    end

    // owner 0 holds while req changes, handover on done
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0001, 1'b0);
      check_eq("hold_grant", 32'(bus.grant), 32'h8);
    end
    step(1'b1, 4'b0001, 1'b1);
    check_eq("handover", 32'(bus.grant), 32'h1);

    // sole requester regranted, then release to idle
    step(1'b1, 4'b0100, 1'b1);
    check_eq("to_owner1", 32'(bus.grant), 32'h4);
    step(1'b1, 4'b0100, 1'b1);
    check_eq("regrant_sole", 32'(bus.grant), 32'h4);
    step(1'b1, 4'b0000, 1'b1);
    check_eq("idle_grant", 32'(bus.grant), 32'h0);
    check_eq("idle_valid", 32'(bus.valid), 32'h0);
    check_eq("idle_owner_sticky", 32'(bus.owner), 32'd1);

    // done while idle has no effect
    step(1'b1, 4'b0000, 1'b1);
    check_eq("done_idle", 32'(bus.grant), 32'h0);

    // reset during a grant
    step(1'b1, 4'b1001, 1'b0);
    check_eq("pre_reset_grant", 32'(bus.grant), 32'h1);
    step(1'b0, 4'b1001, 1'b0);
    check_eq("reset_mid_grant", 32'(bus.grant), 32'h0);
    step(1'b1, 4'b1001, 1'b0);
    check_eq("post_reset_grant", 32'(bus.grant), 32'h8);

    // hold limit
    step(1'b0, 4'b0000, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 4'b1100, 1'b0);
      eg = (TMO_EN && i >= 5) ? 4'b0100 : 4'b1000;
      check_eq($sformatf("tmo_grant%0d", i), 32'(bus.grant), 32'(eg));
      check_eq($sformatf("tmo_pulse%0d", i), 32'(bus.timeout), 32'(TMO_EN && i == 5));
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0));
    end

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
